add_result_stage: RTL and testbench

- Registered output stage directly downstream of the 32-bit carry-lookahead adder.
- Captures the adder's sum and carry-out together with the operands that produced them, derives N/Z/C/V flags, and buffers results in a 2-entry FIFO.
- Delivers results to the next consumer over a valid/ready handshake.
- Keeps a saturating count of signed-overflow results.

---
 rtl/add_result_pkg.sv | 28 ++
 rtl/result_fifo2.sv | 63 ++++++
 rtl/add_result_stage.sv | 88 ++++++++
 tb/tb_add_result_stage.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/add_result_pkg.sv
// Shared types and constants for the adder result stage: flag bit positions,
// saturation limits, the buffered entry layout and the signed-overflow rule.
package add_result_pkg;

  localparam int DATA_W = 32;
  localparam int FLAG_W = 4;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam logic [DATA_W-1:0] SAT_POS = 32'h7FFF_FFFF;
  localparam logic [DATA_W-1:0] SAT_NEG = 32'h8000_0000;

  typedef struct packed {
    logic [DATA_W-1:0] sum;
    logic [FLAG_W-1:0] flags;
  } entry_t;

  // Two's-complement overflow: operands of equal sign produced a result of the other sign.
  function automatic logic signed_overflow(input logic a_sign,
                                           input logic b_eff_sign,
                                           input logic sum_sign);
    return (a_sign == b_eff_sign) && (sum_sign != a_sign);
  endfunction

endpackage

// File: rtl/result_fifo2.sv
// Two-entry valid/ready FIFO for adder result entries. Ready and valid are
// decoded from the registered occupancy count only.
module result_fifo2
  import add_result_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   i_push,
  input  entry_t i_data,
  output logic   o_ready,
  output logic   o_valid,
  input  logic   i_pop,
  output entry_t o_data
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  entry_t           r_mem [2];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_push;
  logic w_pop;

  assign o_ready = (r_count != CNT_W'(DEPTH));
  assign o_valid = (r_count != '0);
  assign w_push  = i_push && o_ready;
  assign w_pop   = i_pop  && o_valid;

  // NOTE: every register here uses <= so all reads in this block see the
  // pre-edge values; mixing in = would make the result depend on statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= '0;
      // NOTE: the storage is reset as well (only two entries) so the head
      // output reads as all-zero after reset instead of stale data.
      r_mem[0] <= '0;
      r_mem[1] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // The head is a pure read of storage, so it cannot move while no pop occurs.
  assign o_data = r_mem[r_rd_ptr];

endmodule

// File: rtl/add_result_stage.sv
// Registered result stage after the 32-bit adder: derives N/Z/C/V, buffers two
// results and counts overflow pops. ADD_RESULT_SATURATE_EN clamps overflowed sums.
module add_result_stage
  import add_result_pkg::*;
#(
  parameter int DEPTH     = 2,
  parameter int OVF_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_W-1:0]    in_a,
  input  logic [DATA_W-1:0]    in_b,
  input  logic                 in_sub,
  input  logic [DATA_W-1:0]    in_sum,
  input  logic                 in_cout,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_W-1:0]    out_sum,
  output logic [FLAG_W-1:0]    out_flags,
  output logic [OVF_CNT_W-1:0] ovf_cnt,
  input  logic                 ovf_clr
);

  logic                 w_b_eff_sign;
  logic                 w_ovf;
  logic [DATA_W-1:0]    w_sum_store;
  entry_t               w_entry;
  entry_t               w_head;
  logic                 w_pop;
  logic                 w_unused_operand_bits;
  logic [OVF_CNT_W-1:0] r_ovf_cnt;

  // Only the operand signs matter here; the low bits are consumed by the adder itself.
  assign w_unused_operand_bits = ^{in_a[DATA_W-2:0], in_b[DATA_W-2:0]};

  assign w_b_eff_sign = in_sub ^ in_b[DATA_W-1];
  assign w_ovf        = signed_overflow(in_a[DATA_W-1], w_b_eff_sign, in_sum[DATA_W-1]);

`ifdef ADD_RESULT_SATURATE_EN
  assign w_sum_store = w_ovf ? (in_a[DATA_W-1] ? SAT_NEG : SAT_POS) : in_sum;
`else
  assign w_sum_store = in_sum;
`endif

  // NOTE: the whole struct gets a default before the field writes, so no
  // path through this block leaves a bit unassigned and no latch is inferred.
  always_comb begin
    w_entry                = '0;
    w_entry.sum            = w_sum_store;
    w_entry.flags[FLAG_N]  = w_sum_store[DATA_W-1];
    w_entry.flags[FLAG_Z]  = (w_sum_store == '0);
    w_entry.flags[FLAG_C]  = in_cout;
    w_entry.flags[FLAG_V]  = w_ovf;
  end

  result_fifo2 #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (in_valid),
    .i_data  (w_entry),
    .o_ready (in_ready),
    .o_valid (out_valid),
    .i_pop   (out_ready),
    .o_data  (w_head)
  );

  assign out_sum   = w_head.sum;
  assign out_flags = w_head.flags;
  assign w_pop     = out_valid && out_ready;

  // Overflow counter: clear wins over an increment, and it sticks at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf_cnt <= '0;
    end else if (ovf_clr) begin
      r_ovf_cnt <= '0;
    end else if (w_pop && w_head.flags[FLAG_V] && (r_ovf_cnt != '1)) begin
      r_ovf_cnt <= r_ovf_cnt + 1'b1;
    end
  end

  assign ovf_cnt = r_ovf_cnt;

endmodule

// File: tb/tb_add_result_stage.sv
// Scoreboard bench for add_result_stage: directed adder results are queued with
// hand-computed expectations and a monitor checks every pop and every stall.
module tb_add_result_stage;

  localparam int CNT_W = 4;

  typedef struct packed {
    logic [31:0] sum;
    logic [3:0]  flags;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_a;
  logic [31:0]      in_b;
  logic             in_sub;
  logic [31:0]      in_sum;
  logic             in_cout;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_sum;
  logic [3:0]       out_flags;
  logic [CNT_W-1:0] ovf_cnt;
  logic             ovf_clr;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb_q[$];

  // Expected results of the overflowing vectors depend on the build.
`ifdef ADD_RESULT_SATURATE_EN
  localparam logic [31:0] POS_OVF_SUM   = 32'h7FFF_FFFF;
  localparam logic [3:0]  POS_OVF_FLAGS = 4'b0001;
  localparam logic [31:0] NEG_OVF_SUM   = 32'h8000_0000;
  localparam logic [3:0]  NEG_OVF_FLAGS = 4'b1011;
`else
  localparam logic [31:0] POS_OVF_SUM   = 32'h8000_0000;
  localparam logic [3:0]  POS_OVF_FLAGS = 4'b1001;
  localparam logic [31:0] NEG_OVF_SUM   = 32'h7FFF_FFFF;
  localparam logic [3:0]  NEG_OVF_FLAGS = 4'b0011;
`endif

  add_result_stage #(
    .DEPTH     (2),
    .OVF_CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sub    (in_sub),
    .in_sum    (in_sum),
    .in_cout   (in_cout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_flags (out_flags),
    .ovf_cnt   (ovf_cnt),
    .ovf_clr   (ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic set_inputs(input logic [31:0] a, input logic [31:0] b, input logic sub,
                            input logic [31:0] sum, input logic cout);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_sub   = sub;
    in_sum   = sum;
    in_cout  = cout;
  endtask

  // Called just after a falling edge; returns just after the falling edge following acceptance.
  task automatic push(input logic [31:0] a, input logic [31:0] b, input logic sub,
                      input logic [31:0] sum, input logic cout,
                      input logic [31:0] exp_sum, input logic [3:0] exp_flags);
    bit accepted = 1'b0;
    set_inputs(a, b, sub, sum, cout);
    for (int cyc = 0; cyc < 20 && !accepted; cyc++) begin
      #4;
      if (in_ready) begin
        sb_q.push_back('{sum: exp_sum, flags: exp_flags});
        accepted = 1'b1;
      end
      @(negedge clk);
    end
    check("push accepted within budget", 32'(accepted), 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic push_pos_ovf();
    push(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, POS_OVF_SUM, POS_OVF_FLAGS);
  endtask

  // Monitor: samples 1 ns before each rising edge, when a pop is about to happen.
  initial begin : monitor
    bit          prev_stall = 1'b0;
    logic [31:0] prev_sum   = '0;
    logic [3:0]  prev_flags = '0;
    exp_t        exp;
    forever begin
      @(negedge clk);
      #4;
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall && out_valid) begin
          check("stall holds out_sum", out_sum, prev_sum);
          check("stall holds out_flags", 32'(out_flags), 32'(prev_flags));
        end
        prev_stall = out_valid && !out_ready;
        prev_sum   = out_sum;
        prev_flags = out_flags;
        if (out_valid && out_ready) begin
          check("scoreboard has entry at pop", 32'(sb_q.size() != 0), 32'd1);
          if (sb_q.size() != 0) begin
            exp = sb_q.pop_front();
            check("popped out_sum", out_sum, exp.sum);
            check("popped out_flags", 32'(out_flags), 32'(exp.flags));
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_sub    = 1'b0;
    in_sum    = '0;
    in_cout   = 1'b0;
    out_ready = 1'b0;
    ovf_clr   = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_sum", out_sum, 32'd0);
    check("reset out_flags", 32'(out_flags), 32'd0);
    check("reset ovf_cnt", 32'(ovf_cnt), 32'd0);

    // 5 + 3: visible the cycle after the push edge.
    out_ready = 1'b1;
    push(32'd5, 32'd3, 1'b0, 32'd8, 1'b0, 32'd8, 4'b0000);
    check("latency out_valid after push", 32'(out_valid), 32'd1);
    check("latency out_sum", out_sum, 32'd8);

    // 3 - 3 then 0 - 1, back to back.
    push(32'd3, 32'd3, 1'b1, 32'd0, 1'b1, 32'd0, 4'b0110);
    push(32'd0, 32'd1, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 4'b1000);

    // Positive overflow on add, negative overflow on subtract.
    push_pos_ovf();
    repeat (2) @(negedge clk);
    check("ovf_cnt after first overflow pop", 32'(ovf_cnt), 32'd1);
    push(32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, NEG_OVF_SUM, NEG_OVF_FLAGS);
    repeat (2) @(negedge clk);
    check("ovf_cnt after second overflow pop", 32'(ovf_cnt), 32'd2);

    // Stall with three results offered.
    out_ready = 1'b0;
    push(32'd10, 32'd20, 1'b0, 32'd30, 1'b0, 32'd30, 4'b0000);
    push(32'd1, 32'd2, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 4'b1000);
    check("in_ready low at two entries", 32'(in_ready), 32'd0);
    set_inputs(32'd100, 32'd1, 1'b0, 32'd101, 1'b0);
    repeat (3) begin
      @(negedge clk);
      check("third push held off", 32'(in_ready), 32'd0);
      check("out_valid during stall", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    push(32'd100, 32'd1, 1'b0, 32'd101, 1'b0, 32'd101, 4'b0000);
    check("push+pop at count 1 keeps out_valid", 32'(out_valid), 32'd1);
    check("push+pop at count 1 keeps in_ready", 32'(in_ready), 32'd1);
    repeat (2) @(negedge clk);
    check("drained out_valid", 32'(out_valid), 32'd0);

    // Saturate the overflow counter (two already counted).
    for (int i = 0; i < 15; i++) push_pos_ovf();
    repeat (3) @(negedge clk);
    check("ovf_cnt saturates at all-ones", 32'(ovf_cnt), 32'(4'hF));

    // Clear alone, then clear coinciding with an overflow pop.
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    check("ovf_clr clears counter", 32'(ovf_cnt), 32'd0);
    push_pos_ovf();
    repeat (2) @(negedge clk);
    check("ovf_cnt counts after clear", 32'(ovf_cnt), 32'd1);
    push_pos_ovf();
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    check("ovf_clr beats increment", 32'(ovf_cnt), 32'd0);

    // Reset with two entries buffered and a push offered during reset.
    out_ready = 1'b0;
    push(32'd7, 32'd8, 1'b0, 32'd15, 1'b0, 32'd15, 4'b0000);
    push(32'd9, 32'd9, 1'b1, 32'd0, 1'b1, 32'd0, 4'b0110);
    rst = 1'b1;
    set_inputs(32'd1, 32'd1, 1'b0, 32'd2, 1'b0);
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    sb_q.delete();
    check("reset flushes out_valid", 32'(out_valid), 32'd0);
    check("reset restores in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    check("push during reset dropped", 32'(out_valid), 32'd0);

    check("scoreboard empty at end", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
